id_ex_issue: RTL
================

ID_EX_ISSUE -- requirements
Module: id_ex_issue

Interface
REQ-001 SHALL have parameter: LINK_OFFSET, 32'd4, constant driven on o_op_b for JAL/JALR link computation.
REQ-002 SHALL have ports, clock and reset first:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  block can accept an instruction this cycle.
- i_instr  in  32  RV32I instruction word.
- i_pc  in  32  PC of i_instr.
- i_rs1_data  in  32  register-file read data for rs1.
- i_rs2_data  in  32  register-file read data for rs2.
- i_flush  in  1  kill held and incoming instruction.
- o_valid  out  1  execute-stage entry valid.
- i_ready  in  1  execute stage accepts entry.
- o_alu_op  out  4  ALU operation code.
- o_op_a  out  32  ALU operand A.
- o_op_b  out  32  ALU operand B.
- o_rd_addr  out  5  destination register.
- o_rd_wren  out  1  writeback enable.
- o_pc  out  32  PC of held instruction.
- o_illegal  out  1  held instruction not decodable.

Function
REQ-003 SHALL use ALU codes ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9, LUI=10; codes 11-15 SHALL never be driven.
REQ-004 SHALL be a single-entry register stage; o_ready = !o_valid | i_ready (combinational).
REQ-005 Load: on rising edge with i_valid & o_ready & !i_flush, SHALL capture the decoded fields and set o_valid=1; latency from accept to o_valid is exactly 1 cycle.
REQ-006 Drain: o_valid & i_ready & no new load SHALL clear o_valid next cycle; load and drain in the same cycle SHALL replace the entry with no bubble.
REQ-007 Stall: o_valid & !i_ready SHALL hold every output bit-stable; o_ready=0.
REQ-008 Flush: i_flush SHALL clear o_valid next cycle and SHALL block any same-cycle load; flush has priority over load and hold.
REQ-009 OP (0110011): rs1/rs2 operands; funct3 000 -> SUB if instr[30] else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 -> SRA if instr[30] else SRL; 110 OR; 111 AND.
REQ-010 OP-IMM (0010011): funct3 mapping as REQ-009, no SUB; op_b = sign-extended instr[31:20]; for funct3 001/101, op_b = {27'b0, instr[24:20]}, SRA if instr[30].
REQ-011 LUI (0110111): alu_op LUI, op_a 0, op_b {instr[31:12],12'b0}; AUIPC (0010111): ADD, op_a i_pc, op_b same U-immediate.
REQ-012 LOAD (0000011): ADD, rs1 + sign-extended I-imm; STORE (0100011): ADD, rs1 + sign-extended {instr[31:25],instr[11:7]}, o_rd_wren 0.
REQ-013 JAL (1101111)/JALR (1100111): ADD, op_a i_pc, op_b LINK_OFFSET.
REQ-014 BRANCH (1100011): SUB, rs1/rs2 operands, o_rd_wren 0.
REQ-015 Any other opcode: o_illegal 1, ADD, operands 0, o_rd_wren 0.
REQ-016 o_rd_wren SHALL be forced 0 whenever rd (instr[11:7]) is 0; o_rd_addr = instr[11:7] always.
REQ-017 All arithmetic 32-bit; no overflow or exception signalling beyond o_illegal.

Reset
REQ-018 On i_clk edge with i_rst_n=0: o_valid 0, o_alu_op 0, o_op_a 0, o_op_b 0, o_rd_addr 0, o_rd_wren 0, o_pc 0, o_illegal 0; reset overrides flush, load and hold.
REQ-019 Reset asserted mid-stall SHALL discard the held entry; first accept after release produces o_valid one cycle later.

Verification
REQ-020 0x402081B3 (sub x3,x1,x2), rs1=10, rs2=3, i_ready=1 -> next cycle o_valid=1, alu_op=1, op_a=10, op_b=3, rd=3, wren=1.
REQ-021 0xFFF00293 (addi x5,x0,-1) -> alu_op=0, op_b=0xFFFFFFFF, rd=5; 0x4030D113 (srai x2,x1,3) -> alu_op=9, op_b=3.
REQ-022 0x123450B7 (lui x1,0x12345) -> alu_op=10, op_a=0, op_b=0x12345000; same word with rd=0 -> wren=0.
REQ-023 Entry held with i_ready=0 for 5 cycles while i_valid=1 -> outputs constant, o_ready=0; i_ready=1 -> next instruction loaded the following cycle, no bubble.
REQ-024 i_flush=1 with i_valid=1 -> o_valid=0 next cycle; i_rst_n=0 during stall -> all outputs 0 next cycle; opcode 0x7F -> o_illegal=1, wren=0.

Source files
------------

// File: rtl/id_ex_issue.sv
// id_ex_issue: RV32I decode-to-execute issue register.
// Decodes one instruction word into ALU op, operands and writeback info,
// and holds it in a single-entry register stage with valid/ready handshake.
module id_ex_issue #(
  parameter logic [31:0] LINK_OFFSET = 32'd4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [3:0]  o_alu_op,
  output logic [31:0] o_op_a,
  output logic [31:0] o_op_b,
  output logic [4:0]  o_rd_addr,
  output logic        o_rd_wren,
  output logic [31:0] o_pc,
  output logic        o_illegal
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Shared funct3 -> ALU op map for OP and OP-IMM. SUB only exists for
  // register-register forms; the immediate form reuses bit 30 as imm data.
  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt,
                                       input logic allow_sub);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_u;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign rd     = i_instr[11:7];
  assign imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_u  = {i_instr[31:12], 12'b0};

  logic [3:0]  dec_op;
  logic [31:0] dec_a, dec_b;
  logic        dec_wren, dec_ill;

  // Combinational decode of the incoming instruction word.
  always_comb begin
    dec_op   = ALU_ADD;
    dec_a    = '0;
    dec_b    = '0;
    dec_wren = 1'b0;
    dec_ill  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_op   = f3_op(funct3, i_instr[30], 1'b1);
        dec_a    = i_rs1_data;
        dec_b    = i_rs2_data;
        dec_wren = 1'b1;
      end
      OPC_OPIMM: begin
        dec_op   = f3_op(funct3, i_instr[30], 1'b0);
        dec_a    = i_rs1_data;
        dec_b    = (funct3 == 3'b001 || funct3 == 3'b101) ?
                   {27'b0, i_instr[24:20]} : imm_i;
        dec_wren = 1'b1;
      end
      OPC_LUI: begin
        dec_op   = ALU_LUI;
        dec_b    = imm_u;
        dec_wren = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a    = i_pc;
        dec_b    = imm_u;
        dec_wren = 1'b1;
      end
      OPC_LOAD: begin
        dec_a    = i_rs1_data;
        dec_b    = imm_i;
        dec_wren = 1'b1;
      end
      OPC_STORE: begin
        dec_a    = i_rs1_data;
        dec_b    = imm_s;
      end
      OPC_JAL, OPC_JALR: begin
        dec_a    = i_pc;
        dec_b    = LINK_OFFSET;
        dec_wren = 1'b1;
      end
      OPC_BRANCH: begin
        dec_op   = ALU_SUB;
        dec_a    = i_rs1_data;
        dec_b    = i_rs2_data;
      end
      default: dec_ill = 1'b1;
    endcase
    // Writes to x0 are architecturally discarded.
    if (rd == 5'd0) dec_wren = 1'b0;
  end

  logic load;
  assign o_ready = !o_valid | i_ready;
  assign load    = i_valid & o_ready & !i_flush;

  // Issue register: reset > flush > load > drain > hold.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_alu_op  <= '0;
      o_op_a    <= '0;
      o_op_b    <= '0;
      o_rd_addr <= '0;
      o_rd_wren <= 1'b0;
      o_pc      <= '0;
      o_illegal <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (load) begin
      o_valid   <= 1'b1;
      o_alu_op  <= dec_op;
      o_op_a    <= dec_a;
      o_op_b    <= dec_b;
      o_rd_addr <= rd;
      o_rd_wren <= dec_wren;
      o_pc      <= i_pc;
      o_illegal <= dec_ill;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
